// File: rtl/reg_wport_if.sv
// Register-file write-port bus: three requesters in, one registered write port out.
interface reg_wport_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;

  logic              hold;
  logic              req0;
  logic              req1;
  logic              req2;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              gnt0;
  logic              gnt1;
  logic              gnt2;
  logic              RW;
  logic [ADDR_W-1:0] DA;
  logic [DATA_W-1:0] Din;
  logic              pc_fault;
  logic              cg_drop;
  logic              starve_active;

  // Requesters, control unit and register file side
  modport master (
    output hold, req0, req1, req2, addr0, addr1, addr2, data0, data1, data2,
    input  gnt0, gnt1, gnt2, RW, DA, Din, pc_fault, cg_drop, starve_active
  );

  // Arbiter side
  modport slave (
    input  hold, req0, req1, req2, addr0, addr1, addr2, data0, data1, data2,
    output gnt0, gnt1, gnt2, RW, DA, Din, pc_fault, cg_drop, starve_active
  );
endinterface

// File: rtl/reg_wport_arbiter.sv
// Register-file write-port arbiter: fixed priority req0 > req1 > req2, with req2
// promoted above req1 for one grant after STARVE_LIMIT consecutive denials.
// Writes to R3 (constant generator) are dropped; low PC writes are flagged.
module reg_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] PC_MIN       = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  reg_wport_if.slave  bus
);

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CLOG_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W   = (CLOG_W > 3) ? CLOG_W : 3;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] CG_ADDR = ADDR_W'(3);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              pc_fault_q, pc_fault_d;
  logic              cg_drop_q, cg_drop_d;

  logic              promote_c;
  logic              gnt0_c, gnt1_c, gnt2_c;
  logic              any_gnt_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;

  // Grant selection; req0 always wins, promoted req2 jumps ahead of req1
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    gnt2_c    = 1'b0;
    promote_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) && bus.req2
                && !bus.hold && !rst;
    if (!rst && !bus.hold) begin
      if (bus.req0)      gnt0_c = 1'b1;
      else if (promote_c) gnt2_c = 1'b1;
      else if (bus.req1) gnt1_c = 1'b1;
      else if (bus.req2) gnt2_c = 1'b1;
    end
  end

  // Winner's address/data mux
  always_comb begin
    any_gnt_c  = gnt0_c | gnt1_c | gnt2_c;
    sel_addr_c = '0;
    sel_data_c = '0;
    if (gnt0_c) begin
      sel_addr_c = bus.addr0;
      sel_data_c = bus.data0;
    end else if (gnt1_c) begin
      sel_addr_c = bus.addr1;
      sel_data_c = bus.data1;
    end else if (gnt2_c) begin
      sel_addr_c = bus.addr2;
      sel_data_c = bus.data2;
    end
  end

  // Next write-port state, fault flags and starvation counter
  always_comb begin
    rw_d         = 1'b0;
    pc_fault_d   = 1'b0;
    cg_drop_d    = 1'b0;
    da_d         = da_q;
    din_d        = din_q;
    starve_cnt_d = starve_cnt_q;

    if (any_gnt_c) begin
      da_d  = sel_addr_c;
      din_d = sel_data_c;
      if (sel_addr_c == CG_ADDR) begin
        cg_drop_d = 1'b1;
      end else begin
        rw_d       = 1'b1;
        pc_fault_d = (sel_addr_c == PC_ADDR) && (sel_data_c < PC_MIN);
      end
    end

    if (!bus.hold) begin
      if (gnt2_c || !bus.req2) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rw_q         <= 1'b0;
      da_q         <= '0;
      din_q        <= '0;
      pc_fault_q   <= 1'b0;
      cg_drop_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rw_q         <= rw_d;
      da_q         <= da_d;
      din_q        <= din_d;
      pc_fault_q   <= pc_fault_d;
      cg_drop_q    <= cg_drop_d;
    end
  end

  assign bus.gnt0          = gnt0_c;
  assign bus.gnt1          = gnt1_c;
  assign bus.gnt2          = gnt2_c;
  assign bus.starve_active = promote_c;
  assign bus.RW            = rw_q;
  assign bus.DA            = da_q;
  assign bus.Din           = din_q;
  assign bus.pc_fault      = pc_fault_q;
  assign bus.cg_drop       = cg_drop_q;

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Bench for reg_wport_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model.
module tb_reg_wport_arbiter;

  localparam int unsigned LIMIT  = 4;
  localparam logic [15:0] PC_MIN = 16'h0200;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic        req  [3];
  logic [3:0]  addr [3];
  logic [15:0] data [3];

  always #5 clk = ~clk;

  reg_wport_if wif ();

  reg_wport_arbiter #(.STARVE_LIMIT(LIMIT), .PC_MIN(PC_MIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  assign wif.hold  = hold;
  assign wif.req0  = req[0];
  assign wif.req1  = req[1];
  assign wif.req2  = req[2];
  assign wif.addr0 = addr[0];
  assign wif.addr1 = addr[1];
  assign wif.addr2 = addr[2];
  assign wif.data0 = data[0];
  assign wif.data1 = data[1];
  assign wif.data2 = data[2];

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Reference model state
  int          cnt = 0;
  logic        exp_rw = 1'b0;
  logic [3:0]  exp_da = '0;
  logic [15:0] exp_din = '0;
  logic        exp_pf = 1'b0;
  logic        exp_cg = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // One clock: check grants against the model, then the registered write port.
  task automatic cycle(output int dut_win);
    int          order [3];
    int          win;
    logic [2:0]  exp_gnt;
    logic        promo;
    #1;
    promo = (cnt == LIMIT) && req[2] && !rst && !hold;
    if (promo) order = '{0, 2, 1};
    else       order = '{0, 1, 2};
    win = -1;
    if (!rst && !hold)
      for (int k = 0; k < 3; k++)
        if (win < 0 && req[order[k]]) win = order[k];
    exp_gnt = (win >= 0) ? 3'(1 << win) : 3'b000;
    chk("gnt", 32'({wif.gnt2, wif.gnt1, wif.gnt0}), 32'(exp_gnt));
    chk("starve_active", 32'(wif.starve_active), 32'(promo));
    dut_win = wif.gnt0 ? 0 : wif.gnt1 ? 1 : wif.gnt2 ? 2 : -1;

    if (rst) begin
      exp_rw = 1'b0; exp_da = '0; exp_din = '0; exp_pf = 1'b0; exp_cg = 1'b0;
      cnt = 0;
    end else begin
      exp_rw = 1'b0; exp_pf = 1'b0; exp_cg = 1'b0;
      if (win >= 0) begin
        exp_da  = addr[win];
        exp_din = data[win];
        exp_cg  = (addr[win] == 4'd3);
        exp_rw  = !exp_cg;
        exp_pf  = (addr[win] == 4'd0) && (data[win] < PC_MIN);
      end
      if (!hold) begin
        if (win == 2 || !req[2]) cnt = 0;
        else if (cnt < LIMIT)    cnt = cnt + 1;
      end
    end

    @(posedge clk);
    #1;
    chk("RW", 32'(wif.RW), 32'(exp_rw));
    chk("DA", 32'(wif.DA), 32'(exp_da));
    chk("Din", 32'(wif.Din), 32'(exp_din));
    chk("pc_fault", 32'(wif.pc_fault), 32'(exp_pf));
    chk("cg_drop", 32'(wif.cg_drop), 32'(exp_cg));
  endtask

  task automatic clr_reqs();
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
  endtask

  task automatic new_req(input int i);
    int r;
    r = int'($urandom % 8);
    req[i]  = 1'b1;
    addr[i] = (r == 0) ? 4'd0 : (r == 1) ? 4'd3 : 4'($urandom);
    data[i] = ($urandom % 2 == 0) ? 16'($urandom_range(0, 16'h03ff)) : 16'($urandom);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; addr[i] = '0; data[i] = '0;
    end
    @(posedge clk);
    #1;
    phase = "reset";
    cycle(w);
    cycle(w);
    rst = 1'b0;
    cycle(w);

    phase = "single";
    req[1] = 1'b1; addr[1] = 4'd4; data[1] = 16'hBEEF;
    cycle(w);
    chk("win", 32'(w), 32'(1));
    chk("RW_on", 32'(wif.RW), 32'(1));
    chk("DA", 32'(wif.DA), 32'(4));
    chk("Din", 32'(wif.Din), 32'hBEEF);
    req[1] = 1'b0;
    cycle(w);
    chk("RW_off", 32'(wif.RW), 32'(0));

    phase = "priority";
    req[0] = 1'b1; addr[0] = 4'd1; data[0] = 16'h1111;
    req[1] = 1'b1; addr[1] = 4'd2; data[1] = 16'h2222;
    req[2] = 1'b1; addr[2] = 4'd5; data[2] = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      cycle(w);
      chk("order", 32'(w), 32'(k));
      if (w >= 0) req[w] = 1'b0;
    end
    cycle(w);

    phase = "starve";
    req[1] = 1'b1; addr[1] = 4'd6; data[1] = 16'h0666;
    req[2] = 1'b1; addr[2] = 4'd7; data[2] = 16'h0777;
    for (int k = 0; k < 4; k++) begin
      cycle(w);
      chk("deny", 32'(w), 32'(1));
    end
    cycle(w);
    chk("promote", 32'(w), 32'(2));
    chk("DA_promote", 32'(wif.DA), 32'(7));
    req[2] = 1'b0;
    cycle(w);
    chk("resume", 32'(w), 32'(1));

    phase = "starve_req0";
    req[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(w);
      chk("deny", 32'(w), 32'(1));
    end
    req[0] = 1'b1; addr[0] = 4'd8; data[0] = 16'h0888;
    cycle(w);
    chk("req0_first", 32'(w), 32'(0));
    req[0] = 1'b0;
    cycle(w);
    chk("promote", 32'(w), 32'(2));
    clr_reqs();
    cycle(w);

    phase = "pc_fault";
    req[1] = 1'b1; addr[1] = 4'd0; data[1] = 16'h0100;
    cycle(w);
    chk("pf_on", 32'(wif.pc_fault), 32'(1));
    chk("RW", 32'(wif.RW), 32'(1));
    req[1] = 1'b0;
    cycle(w);
    chk("pf_off", 32'(wif.pc_fault), 32'(0));

    phase = "cg_drop";
    req[2] = 1'b1; addr[2] = 4'd3; data[2] = 16'h1234;
    cycle(w);
    chk("win", 32'(w), 32'(2));
    chk("cg_on", 32'(wif.cg_drop), 32'(1));
    chk("RW", 32'(wif.RW), 32'(0));
    chk("Din", 32'(wif.Din), 32'h1234);
    req[2] = 1'b0;
    cycle(w);

    phase = "hold";
    hold = 1'b1;
    req[1] = 1'b1; addr[1] = 4'd9; data[1] = 16'h0999;
    for (int k = 0; k < 3; k++) begin
      cycle(w);
      chk("no_gnt", 32'(w), 32'hFFFF_FFFF);
    end
    hold = 1'b0;
    cycle(w);
    chk("after_hold", 32'(w), 32'(1));
    chk("DA", 32'(wif.DA), 32'(9));

    phase = "reset_mid";
    addr[1] = 4'd10; data[1] = 16'h0AAA;
    rst = 1'b1;
    cycle(w);
    chk("RW", 32'(wif.RW), 32'(0));
    chk("DA", 32'(wif.DA), 32'(0));
    chk("Din", 32'(wif.Din), 32'(0));
    rst = 1'b0;
    clr_reqs();
    cycle(w);

    phase = "random";
    for (int c = 0; c < 800; c++) begin
      hold = ($urandom % 8 == 0);
      rst  = ($urandom % 64 == 0);
      cycle(w);
      if (rst) begin
        clr_reqs();
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (w == i) begin
            if ($urandom % 2 == 0) new_req(i);
            else req[i] = 1'b0;
          end else if (!req[i] && ($urandom % 3 == 0)) begin
            new_req(i);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wport_arbiter.md
Name: reg_wport_arbiter

Overview:
- Shares the register file's single write port (RW, DA, Din) among three requesters:
  - interrupt/exception sequencer (req 0)
  - execute-stage writeback (req 1)
  - memory-load writeback (req 2)
- Fixed priority with an anti-starvation override for req 2.
- Registered outputs feed the register file directly.
- Flags illegal writes: PC targets below the valid code region, and the read-only constant generator R3.

Parameters:
- STARVE_LIMIT, 4, consecutive denied cycles of req 2 before it is promoted above req 1 for one grant.
- PC_MIN, 16'h0200, lowest legal value written to R0; writes below it raise pc_fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hold  in  1  control-unit freeze; no grants issued while high
- req0, req1, req2  in  1 each  write request, held high until granted
- addr0, addr1, addr2  in  4 each  destination register (DA) per requester
- data0, data1, data2  in  16 each  write data per requester
- gnt0, gnt1, gnt2  out  1 each  combinational grant, one-hot or all zero
- RW  out  1  registered register-file write enable
- DA  out  4  registered destination address
- Din  out  16  registered write data
- pc_fault  out  1  registered; granted write targeted R0 with data < PC_MIN
- cg_drop  out  1  registered; granted write targeted R3 and was discarded
- starve_active  out  1  combinational; promotion of req 2 in effect this cycle

Behaviour:
- Reset: RW=0, DA=0, Din=0, pc_fault=0, cg_drop=0, starvation counter=0. gnt* are 0 during any cycle with rst high.
- Grant is combinational from req*, hold and counter state. At most one gnt per cycle.
- Normal priority: req0 > req1 > req2.
- Promotion: when counter == STARVE_LIMIT and req2=1, order becomes req0 > req2 > req1, and starve_active=1.
  - req0 is never preempted.
- Starvation counter (3-bit min, saturating at STARVE_LIMIT):
  - increments when req2=1, hold=0 and gnt2=0;
  - clears when gnt2=1 or req2=0;
  - unchanged while hold=1.
- hold=1: all gnt=0. On the next edge RW=0, pc_fault=0, cg_drop=0; DA and Din keep their previous values.
- Latency: the grant in cycle N produces a write on the edge ending N. RW/DA/Din are valid during N+1, so the register file commits at the edge ending N+1.
- A requester deasserts req (or presents its next transfer) in the cycle after its grant. Back-to-back grants to the same requester are allowed.
- No request or no grant: RW=0 next cycle; DA/Din hold.
- addr==4'd3 granted:
  - gnt is still issued, so the requester completes;
  - next cycle RW=0, cg_drop=1, DA/Din updated to the addr/data.
- addr==4'd0 with data < PC_MIN granted:
  - RW=1, DA=0, Din=data are forwarded unchanged; the register file applies its reset-vector redirect;
  - pc_fault=1 for one cycle.
- pc_fault and cg_drop are single-cycle pulses and are mutually exclusive.
- No coalescing: simultaneous requests to the same DA are serialized in priority order. The lower-priority write lands last and wins.
- Reset mid-operation: a write granted in the same cycle as rst is lost. Outputs are zero the next cycle, and requesters must re-request after reset.
- Requests sampled with X are not checked. Requesters guarantee addr/data are stable whenever req=1.

Test Plan:
- Single request: req1=1, addr1=4, data1=16'hBEEF -> gnt1=1 in the same cycle; next cycle RW=1, DA=4, Din=16'hBEEF; then RW=0.
- Priority: req0, req1 and req2 all asserted with distinct addrs, each req dropped after its grant -> grant order 0,1,2 on three consecutive cycles; RW/DA follow one cycle later.
- Starvation, STARVE_LIMIT=4, req1 held continuously, req2 held:
  - req2 denied cycles 1-4; cycle 5 gnt2=1 and starve_active=1;
  - cycle 6 gnt1 resumes and the counter is back to 0.
- Same scenario plus req0 pulsed in cycle 5 -> gnt0 in cycle 5, gnt2 in cycle 6.
- Illegal targets:
  - req1 addr1=0, data1=16'h0100 -> RW=1, DA=0, pc_fault=1 for one cycle;
  - req2 addr2=3, data2=16'h1234 -> gnt2=1, next cycle RW=0, cg_drop=1.
- Hold/reset:
  - hold=1 for 3 cycles with req1 pending -> no gnt, RW=0, counter frozen; grant in the first cycle after hold drops;
  - rst during a granted cycle -> next cycle RW=0, DA=0, Din=0.
